// File: rtl/change_event_logger.sv
// rtl/change_event_logger.sv - timestamped change-event capture into a show-ahead FIFO
// Logs {value, cycle timestamp} whenever the observed bus changes; consumer drains via valid/ready.
module change_event_logger #(
  parameter int DATA_W = 3,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        sample_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   P_ONE   = AW'(1);
  localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);

  logic [TS_W-1:0]   r_ts;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [TS_W-1:0]   r_mem_ts   [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [TS_W-1:0]   r_out_ts;
  logic              r_overflow;

  logic              w_event;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [AW-1:0]     w_rptr_nxt;
  logic [AW:0]       w_count_nxt;
  logic [DATA_W-1:0] w_head_data;
  logic [TS_W-1:0]   w_head_ts;

  always_comb begin
    w_event     = !r_prev_valid || (sample_in != r_prev);
    w_full      = (r_count == C_FULL);
    w_pop       = r_valid && out_ready;
    // A pop on a full FIFO frees the slot the same edge, so the event still lands.
    w_push      = w_event && (!w_full || w_pop);
    w_drop      = w_event && w_full && !w_pop;
    w_rptr_nxt  = w_pop ? (r_rptr + P_ONE) : r_rptr;
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + C_ONE;
    else if (!w_push && w_pop) w_count_nxt = r_count - C_ONE;
    // Next head is the record being written when it lands exactly at the new read pointer.
    if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_data = sample_in;
      w_head_ts   = r_ts;
    end else begin
      w_head_data = r_mem_data[w_rptr_nxt];
      w_head_ts   = r_mem_ts[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_data[r_wptr] <= sample_in;
      r_mem_ts[r_wptr]   <= r_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts         <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_out_data   <= '0;
      r_out_ts     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_ts         <= r_ts + TS_ONE;
      r_prev       <= sample_in;
      r_prev_valid <= 1'b1;
      if (w_push) r_wptr <= r_wptr + P_ONE;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_valid      <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_out_data <= w_head_data;
        r_out_ts   <= w_head_ts;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_out_data;
  assign out_ts    = r_out_ts;
  assign count     = r_count;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_change_event_logger.sv
// tb/tb_change_event_logger.sv - directed-vector bench for change_event_logger
// Default instance covers FIFO behaviour; a TS_W=4 instance covers timestamp wrap.
module tb_change_event_logger;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sample_in;
  logic        out_ready;
  logic        out_valid;
  logic [2:0]  out_data;
  logic [15:0] out_ts;
  logic [3:0]  count;
  logic        overflow;
  logic        v4;
  logic [2:0]  d4;
  logic [3:0]  ts4;
  logic [3:0]  c4;
  logic        o4;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  change_event_logger dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
    .count(count), .overflow(overflow)
  );

  change_event_logger #(.TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .out_valid(v4),
    .out_ready(out_ready), .out_data(d4), .out_ts(ts4),
    .count(c4), .overflow(o4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [2:0] tog(input int e);
    return (e % 2 == 1) ? 3'b101 : 3'b010;
  endfunction

  task automatic test_reset;
    rst = 1'b1; sample_in = 3'b101; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %0b exp 0", out_valid); n_err++; end n_vec++;
    if (count !== 4'd0) begin $display("FAIL reset_count got %0d exp 0", count); n_err++; end n_vec++;
    if (overflow !== 1'b0) begin $display("FAIL reset_overflow got %0b exp 0", overflow); n_err++; end n_vec++;
    if (out_data !== 3'b000) begin $display("FAIL reset_data got %0b exp 000", out_data); n_err++; end n_vec++;
    if (out_ts !== 16'd0) begin $display("FAIL reset_ts got %0d exp 0", out_ts); n_err++; end n_vec++;
  endtask

  task automatic test_steady;
    do_reset();
    sample_in = 3'b010; out_ready = 1'b1;
    tick();
    if (out_valid !== 1'b1 || out_data !== 3'b010 || out_ts !== 16'd0)
      begin $display("FAIL steady_first got v=%0b d=%0b ts=%0d exp v=1 d=010 ts=0", out_valid, out_data, out_ts); n_err++; end n_vec++;
    tick();
    if (count !== 4'd0 || out_valid !== 1'b0)
      begin $display("FAIL steady_popped got count=%0d v=%0b exp 0 0", count, out_valid); n_err++; end n_vec++;
    if (out_data !== 3'b010 || out_ts !== 16'd0)
      begin $display("FAIL steady_hold got d=%0b ts=%0d exp 010 0", out_data, out_ts); n_err++; end n_vec++;
    for (int i = 0; i < 18; i++) tick();
    if (count !== 4'd0 || overflow !== 1'b0)
      begin $display("FAIL steady_end got count=%0d ovf=%0b exp 0 0", count, overflow); n_err++; end n_vec++;
  endtask

  task automatic test_spaced;
    logic [2:0]  exp_d [4];
    logic [15:0] exp_t [4];
    exp_d[0] = 3'b010; exp_t[0] = 16'd0;
    exp_d[1] = 3'b011; exp_t[1] = 16'd2;
    exp_d[2] = 3'b001; exp_t[2] = 16'd12;
    exp_d[3] = 3'b110; exp_t[3] = 16'd22;
    do_reset();
    out_ready = 1'b0;
    for (int e = 0; e <= 22; e++) begin
      sample_in = (e < 2) ? 3'b010 : (e < 12) ? 3'b011 : (e < 22) ? 3'b001 : 3'b110;
      tick();
    end
    if (count !== 4'd4) begin $display("FAIL spaced_count got %0d exp 4", count); n_err++; end n_vec++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_ts !== exp_t[i])
        begin $display("FAIL spaced_rec%0d got v=%0b d=%0b ts=%0d exp v=1 d=%0b ts=%0d", i, out_valid, out_data, out_ts, exp_d[i], exp_t[i]); n_err++; end n_vec++;
      tick();
    end
    if (count !== 4'd0) begin $display("FAIL spaced_drained got %0d exp 0", count); n_err++; end n_vec++;
  endtask

  task automatic test_overflow;
    do_reset();
    out_ready = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      sample_in = tog(e);
      tick();
      if (e == 7 && (count !== 4'd8 || overflow !== 1'b0))
        begin $display("FAIL ovf_at_full got count=%0d ovf=%0b exp 8 0", count, overflow); n_err++; end
      if (e == 7) n_vec++;
      if (e == 8 && (count !== 4'd8 || overflow !== 1'b1))
        begin $display("FAIL ovf_dropped got count=%0d ovf=%0b exp 8 1", count, overflow); n_err++; end
      if (e == 8) n_vec++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_data !== tog(i) || out_ts !== 16'(i))
        begin $display("FAIL ovf_rec%0d got d=%0b ts=%0d exp d=%0b ts=%0d", i, out_data, out_ts, tog(i), i); n_err++; end n_vec++;
      tick();
    end
    if (count !== 4'd0 || overflow !== 1'b1)
      begin $display("FAIL ovf_sticky got count=%0d ovf=%0b exp 0 1", count, overflow); n_err++; end n_vec++;
  endtask

  task automatic test_full_pop_push;
    do_reset();
    out_ready = 1'b0;
    for (int e = 0; e < 8; e++) begin
      sample_in = tog(e);
      tick();
    end
    out_ready = 1'b1;
    sample_in = tog(8);
    tick();
    if (count !== 4'd8 || overflow !== 1'b0)
      begin $display("FAIL fullpp_count got count=%0d ovf=%0b exp 8 0", count, overflow); n_err++; end n_vec++;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid !== 1'b1 || out_data !== tog(i) || out_ts !== 16'(i))
        begin $display("FAIL fullpp_rec%0d got v=%0b d=%0b ts=%0d exp v=1 d=%0b ts=%0d", i, out_valid, out_data, out_ts, tog(i), i); n_err++; end n_vec++;
      tick();
    end
    if (count !== 4'd0 || overflow !== 1'b0)
      begin $display("FAIL fullpp_end got count=%0d ovf=%0b exp 0 0", count, overflow); n_err++; end n_vec++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    out_ready = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      sample_in = tog(e);
      tick();
      if (count !== 4'd1 || out_data !== tog(e) || out_ts !== 16'(e))
        begin $display("FAIL b2b_edge%0d got count=%0d d=%0b ts=%0d exp 1 %0b %0d", e, count, out_data, out_ts, tog(e), e); n_err++; end n_vec++;
    end
    tick();
    if (count !== 4'd0 || out_valid !== 1'b0)
      begin $display("FAIL b2b_end got count=%0d v=%0b exp 0 0", count, out_valid); n_err++; end n_vec++;
  endtask

  task automatic test_wrap;
    logic [2:0] exp_d [3];
    logic [3:0] exp_t [3];
    exp_d[0] = 3'b000; exp_t[0] = 4'd0;
    exp_d[1] = 3'b111; exp_t[1] = 4'd14;
    exp_d[2] = 3'b100; exp_t[2] = 4'd1;
    do_reset();
    out_ready = 1'b0;
    for (int e = 0; e <= 17; e++) begin
      sample_in = (e < 14) ? 3'b000 : (e < 17) ? 3'b111 : 3'b100;
      tick();
    end
    if (c4 !== 4'd3) begin $display("FAIL wrap_count got %0d exp 3", c4); n_err++; end n_vec++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (v4 !== 1'b1 || d4 !== exp_d[i] || ts4 !== exp_t[i])
        begin $display("FAIL wrap_rec%0d got v=%0b d=%0b ts=%0d exp v=1 d=%0b ts=%0d", i, v4, d4, ts4, exp_d[i], exp_t[i]); n_err++; end n_vec++;
      tick();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_ready = 1'b0;
    for (int e = 0; e <= 9; e++) begin
      sample_in = tog(e);
      tick();
    end
    out_ready = 1'b1;
    tick(); tick(); tick();
    if (count !== 4'd5 || overflow !== 1'b1)
      begin $display("FAIL mid_prep got count=%0d ovf=%0b exp 5 1", count, overflow); n_err++; end n_vec++;
    rst = 1'b1;
    sample_in = 3'b000;
    tick();
    rst = 1'b0;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0)
      begin $display("FAIL mid_cleared got v=%0b count=%0d ovf=%0b exp 0 0 0", out_valid, count, overflow); n_err++; end n_vec++;
    if (out_data !== 3'b000 || out_ts !== 16'd0)
      begin $display("FAIL mid_zero got d=%0b ts=%0d exp 000 0", out_data, out_ts); n_err++; end n_vec++;
    sample_in = 3'b110;
    tick();
    if (out_valid !== 1'b1 || out_data !== 3'b110 || out_ts !== 16'd0 || count !== 4'd1)
      begin $display("FAIL mid_first got v=%0b d=%0b ts=%0d count=%0d exp 1 110 0 1", out_valid, out_data, out_ts, count); n_err++; end n_vec++;
  endtask

  initial begin
    rst = 1'b1; sample_in = 3'b000; out_ready = 1'b0;
    test_reset();
    test_steady();
    test_spaced();
    test_overflow();
    test_full_pop_push();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/change_event_logger.md
# change_event_logger

Synthesizable capture-side counterpart to our timed stimulus drivers. Samples a small parallel bus every clock, detects value changes, tags each change with a free-running cycle timestamp, and buffers (value, timestamp) records in an internal FIFO. A consumer drains the records through a valid/ready handshake. Sits between the driven logic under observation and any readout path (UART dumper, ILA-style readback, bench scoreboard).

## Interface
- DATA_W, 3: width of observed bus (e.g. {x,y,z}).
- TS_W, 16: timestamp counter width.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  observed bus, sampled every edge.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record when out_valid & out_ready.
- out_data  out  DATA_W  value of head record.
- out_ts  out  TS_W  timestamp of head record.
- count  out  clog2(DEPTH)+1  records currently stored.
- overflow  out  1  sticky: at least one event dropped since reset.

## Operation
- Reset (rst=1 at an edge): ts counter=0, prev_valid=0, prev=0, FIFO empty; outputs out_valid=0, out_data=0, out_ts=0, count=0, overflow=0. Reset overrides everything in the same cycle, including a pending pop or event; FIFO contents are discarded.
- Timestamp: TS_W-bit counter, +1 every non-reset edge, wraps 2^TS_W-1 -> 0 silently; no wrap record.
- Event: at a non-reset edge, event=1 when prev_valid=0 (first sample after reset) or sample_in != prev. Then prev <= sample_in, prev_valid <= 1.
- Event record = {sample_in, ts value before this edge's increment}.
- Push: event with FIFO not full -> record written. Event with FIFO full and no pop this edge -> record dropped, overflow <= 1 (stays 1 until reset).
- Full with simultaneous pop (out_valid & out_ready) and event: pop and push both happen; count unchanged; no overflow.
- Pop: out_valid & out_ready at an edge removes head. out_ready while empty ignored.
- Simultaneous push and pop on non-empty, non-full FIFO: count unchanged.
- Push into empty FIFO with out_ready=1: record is not popped that edge (it was not yet visible); it appears next cycle.
- out_data/out_ts are show-ahead: reflect head whenever out_valid=1; hold last head value (or 0 after reset) when empty, not X.
- count ranges 0..DEPTH; out_valid = (count != 0).

## Timing
- Event-to-visibility latency: 1 cycle. sample_in change present before edge N -> out_valid=1 with that record after edge N.
- First post-reset edge always logs: record {sample_in, ts=0}.
- Steady input produces no records.
- Throughput: one event and one pop per cycle, sustained.
- Only registered outputs; no combinational path from sample_in or out_ready to any output.
- No timestamp gap: consecutive changing cycles give consecutive ts values.

## Test plan
- Reset then sample_in=3'b010 steady 20 cycles, out_ready=1 -> exactly one record {010, ts=0}; count returns to 0; overflow=0.
- out_ready=0; sample_in 010, changes to 011 at edge 2, 001 at edge 12, 110 at edge 22 -> records {010,0},{011,2},{001,12},{110,22}, count=4; then out_ready=1 drains them in that order, one per cycle.
- DEPTH=8, out_ready=0, toggle sample_in every cycle for 10 edges -> count=8, first 8 records kept with ts 0..7, overflow=1 after edge 8, stays 1 after full drain.
- FIFO full, out_ready=1 with a change on same edge -> head popped, new record appended, count stays 8, overflow stays 0.
- TS_W=4, change at edges 14 and 17 -> ts 14 then 1 (wrap).
- Assert rst mid-stream with 5 records held and out_ready=1 -> next cycle out_valid=0, count=0, overflow=0, ts restarts at 0, first post-reset sample logged.
